// File: rtl/div_pkg.sv
// Shared definitions for the signed divider pre/post-processing slice.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  // Widest operand the constant helpers below can describe.
  localparam int unsigned MAX_WIDTH = 128;

  // Sign/exception flags captured alongside the operand magnitudes.
  typedef struct packed {
    logic neg_q;
    logic neg_r;
    logic dbz;
    logic ovf;
  } s1_flags_t;

  // Most-negative two's-complement value of width w, LSB-aligned.
  function automatic logic [MAX_WIDTH-1:0] most_neg(input int unsigned w);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    v[w-1] = 1'b1;
    return v;
  endfunction

  // All-ones value of width w, LSB-aligned.
  function automatic logic [MAX_WIDTH-1:0] all_ones(input int unsigned w);
    return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - w);
  endfunction

endpackage

// File: rtl/sdiv_fixup.sv
// Result selection and sign restoration in front of the output register.
module sdiv_fixup
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] core_q_i,
  input  logic [WIDTH-1:0] core_r_i,
  input  s1_flags_t        flags_i,
  input  logic [WIDTH-1:0] x_raw_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] r_o,
  output logic             dbz_o,
  output logic             ovf_o
);

  localparam logic [MAX_WIDTH-1:0] MOST_NEG_FULL = most_neg(WIDTH);
  localparam logic [WIDTH-1:0]     MOST_NEG      = MOST_NEG_FULL[WIDTH-1:0];

  // Divide-by-zero wins over overflow; otherwise restore signs on the core result.
  always_comb begin
    q_o   = flags_i.neg_q ? -core_q_i : core_q_i;
    r_o   = flags_i.neg_r ? -core_r_i : core_r_i;
    dbz_o = flags_i.dbz;
    ovf_o = flags_i.ovf;
    if (flags_i.dbz) begin
      q_o   = '1;
      r_o   = x_raw_i;
      ovf_o = 1'b0;
    end else if (flags_i.ovf) begin
      q_o = MOST_NEG;
      r_o = '0;
    end
  end

endmodule

// File: rtl/sdiv_prepost.sv
// Two-stage signed/unsigned wrapper around an unsigned combinational divider.
module sdiv_prepost
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic [WIDTH-1:0] core_x,
  output logic [WIDTH-1:0] core_y,
  input  logic [WIDTH-1:0] core_q,
  input  logic [WIDTH-1:0] core_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic             out_dbz,
  output logic             out_ovf
);

  localparam logic [MAX_WIDTH-1:0] MOST_NEG_FULL = most_neg(WIDTH);
  localparam logic [MAX_WIDTH-1:0] ALL_ONES_FULL = all_ones(WIDTH);
  localparam logic [WIDTH-1:0]     MOST_NEG      = MOST_NEG_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     ALL_ONES      = ALL_ONES_FULL[WIDTH-1:0];

  // Stage S1 state
  logic             s1_valid_q;
  logic [WIDTH-1:0] core_x_q, core_x_d;
  logic [WIDTH-1:0] core_y_q, core_y_d;
  logic [WIDTH-1:0] x_raw_q;
  s1_flags_t        flags_q, flags_d;

  // Stage S2 state
  logic             out_valid_q;
  logic [WIDTH-1:0] out_q_q, out_r_q;
  logic             out_dbz_q, out_ovf_q;

  // Fixup outputs feeding S2
  logic [WIDTH-1:0] fix_q, fix_r;
  logic             fix_dbz, fix_ovf;

  logic accept;
  logic s2_load;

  assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Operand magnitudes and sign/exception flags for S1. The most-negative
  // value negates to itself, which is already its correct unsigned magnitude.
  always_comb begin
    core_x_d      = (in_signed && in_x[WIDTH-1]) ? -in_x : in_x;
    core_y_d      = (in_signed && in_y[WIDTH-1]) ? -in_y : in_y;
    flags_d.neg_q = in_signed && (in_x[WIDTH-1] ^ in_y[WIDTH-1]);
    flags_d.neg_r = in_signed && in_x[WIDTH-1];
    flags_d.dbz   = (in_y == '0);
    flags_d.ovf   = in_signed && (in_x == MOST_NEG) && (in_y == ALL_ONES);
  end

  // S1 register: capture operands on accept; valid drops only when drained without refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      core_x_q   <= '0;
      core_y_q   <= '0;
      x_raw_q    <= '0;
      flags_q    <= '0;
    end else begin
      if (accept) begin
        s1_valid_q <= 1'b1;
        core_x_q   <= core_x_d;
        core_y_q   <= core_y_d;
        x_raw_q    <= in_x;
        flags_q    <= flags_d;
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  sdiv_fixup #(
    .WIDTH(WIDTH)
  ) u_fixup (
    .core_q_i(core_q),
    .core_r_i(core_r),
    .flags_i (flags_q),
    .x_raw_i (x_raw_q),
    .q_o     (fix_q),
    .r_o     (fix_r),
    .dbz_o   (fix_dbz),
    .ovf_o   (fix_ovf)
  );

  // S2 register: load the corrected result; hold it while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q_q     <= '0;
      out_r_q     <= '0;
      out_dbz_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid_q <= 1'b1;
        out_q_q     <= fix_q;
        out_r_q     <= fix_r;
        out_dbz_q   <= fix_dbz;
        out_ovf_q   <= fix_ovf;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign core_x    = core_x_q;
  assign core_y    = core_y_q;
  assign out_valid = out_valid_q;
  assign out_q     = out_q_q;
  assign out_r     = out_r_q;
  assign out_dbz   = out_dbz_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: doc/sdiv_prepost.md
# sdiv_prepost

Signed/unsigned pre- and post-processing pipeline around the combinational unsigned restoring-division array. Accepts operands over a valid/ready handshake and registers their magnitudes. The magnitudes drive the unsigned core, and the block captures the core's quotient and remainder. It then applies sign correction and divide-by-zero/overflow rules and presents a registered result downstream. The block sits between the ALU issue logic and the unsigned divider core and adds exactly two register stages.

## Interface
- WIDTH, 32, operand/result width (≥2)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept operands this cycle
- in_signed  in  1  1 = two's-complement division, 0 = unsigned
- in_x  in  WIDTH  dividend
- in_y  in  WIDTH  divisor
- core_x  out  WIDTH  dividend magnitude to unsigned core (registered)
- core_y  out  WIDTH  divisor magnitude to unsigned core (registered)
- core_q  in  WIDTH  unsigned quotient from core (combinational from core_x/core_y)
- core_r  in  WIDTH  unsigned remainder from core
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_q  out  WIDTH  final quotient
- out_r  out  WIDTH  final remainder
- out_dbz  out  1  divisor was zero
- out_ovf  out  1  signed overflow (most-negative / −1)

## Operation
- Stage S1 loads on in_valid && in_ready and captures the following:
  - core_x = in_signed && in_x[MSB] ? −in_x : in_x
  - core_y is formed the same way from in_y.
  - neg_q = in_signed && (in_x[MSB] ^ in_y[MSB])
  - neg_r = in_signed && in_x[MSB]
  - dbz = (in_y == 0)
  - ovf = in_signed && in_x == {1,0…0} && in_y == all-ones
  - x_raw = in_x
- The magnitude of the most-negative value is 2^(WIDTH−1) and is represented unchanged as unsigned. No special case is needed in S1.
- Stage S2 loads from S1 when s1_valid && (!out_valid || out_ready). Result selection, in priority order:
  - dbz: out_q = all-ones, out_r = x_raw, out_ovf = 0.
  - ovf: out_q = {1,0…0}, out_r = 0.
  - otherwise: out_q = neg_q ? −core_q : core_q, and out_r = neg_r ? −core_r : core_r. The remainder takes the dividend's sign and the quotient truncates toward zero.
- in_ready = !s1_valid || !out_valid || out_ready (combinational, no skid buffer).
- s1_valid: set on accept; cleared when S2 loads without a simultaneous accept. Simultaneous accept and S2 load keeps s1_valid = 1 with the new operands.
- out_valid: set on S2 load; cleared on out_ready without a new load.
- Results leave in issue order; no reordering or dropping.
- Behaviour in unsigned mode (in_signed = 0):
  - No negation on either side.
  - ovf is never set.
  - dbz is handled identically to signed mode.

## Timing
- Reset values:
  - s1_valid = 0, out_valid = 0.
  - core_x, core_y, out_q, out_r = 0.
  - out_dbz, out_ovf = 0.
  - in_ready = 1.
- Latency: operands accepted at edge N appear with out_valid = 1 after edge N+1, provided downstream is not stalled.
- Throughput: one result per cycle while out_ready = 1.
- Stall:
  - With out_ready = 0, at most two operations are held, one in S1 and one in S2.
  - in_ready drops to 0 in the cycle both stages are full.
  - in_ready returns combinationally when out_ready rises.
- Outputs are stable while out_valid && !out_ready.
- in_x, in_y and in_signed are sampled only on accept.
- core_* paths:
  - core_x/core_y are flop outputs.
  - core_q/core_r feed only the S2 D-inputs. The core delay plus sign fixup must fit one clock period.
- Asserting rst mid-operation discards both stages immediately (asynchronously). The first accept is possible on the first edge after deassertion.

## Structure
- Shared package div_pkg holds the following:
  - DIV_WIDTH default (32).
  - A typedef for the S1 flags struct {neg_q, neg_r, dbz, ovf}.
  - Constant functions for most-negative and all-ones of a given width.
- One sub-module, sdiv_fixup: combinational result selection and negation, from {core_q, core_r, flags, x_raw} to {q, r, dbz, ovf}. It is instantiated once in front of S2.
- Pipeline control (valid bits, in_ready) lives in the top module.

## Test plan
- Signed −7 / 2 (in_x = 0xFFFFFFF9, in_y = 2): core_x = 7, core_y = 2. Result out_q = 0xFFFFFFFD, out_r = 0xFFFFFFFF, flags 0, out_valid two edges after accept.
- Signed 7 / −2: out_q = 0xFFFFFFFD, out_r = 1. The same operands in unsigned mode give out_q = 0, out_r = 7.
- Signed 0x80000000 / 0xFFFFFFFF: out_ovf = 1, out_q = 0x80000000, out_r = 0. In unsigned mode: out_q = 0, out_r = 0x80000000, out_ovf = 0.
- Divide-by-zero 5 / 0 in both modes: out_dbz = 1, out_q = 0xFFFFFFFF, out_r = 5.
- Backpressure: issue 100/3, 50/7, 9/9 back-to-back with out_ready = 0.
  - in_ready falls after two accepts.
  - After out_ready = 1, results emerge in order: (33,1), (7,1), (1,0).
  - Results are held stable while stalled.
- Assert rst with both stages full: out_valid = 0, in_ready = 1 and outputs = 0 immediately. The next operation completes normally.
